// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce bank.
// Channel FSM state encoding and default filter lengths.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        DOWN,
        REL_CHK
    } ch_state_e;

    localparam int DEB_MAX_SIM  = 5;
    localparam int DEB_MAX_FPGA = 40000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, press/release debounce FSM,
// and a one-shot long-press counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEB_MAX  = 5,
    parameter int HOLD_MAX = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int DW = $clog2(DEB_MAX);
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam bit HOLD_EN = (HOLD_MAX != 0);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    logic          sync1_q;
    logic          s_q;
    ch_state_e     state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          fired_q, fired_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_q) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = DW'(1);
                end
            end
            PRESS_CHK: begin
                if (!s_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = DOWN;
                    level_d   = 1'b1;
                    press_d   = 1'b1;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            DOWN: begin
                if (!s_q) begin
                    state_d   = REL_CHK;
                    deb_cnt_d = DW'(1);
                end
            end
            REL_CHK: begin
                if (s_q) begin
                    state_d   = DOWN;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Clearing on level_d keeps hold off the release cycle; counting on
    // level_q starts the count on the cycle after the press strobe.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        fired_d    = fired_q;
        hold_d     = 1'b0;
        if (!level_d) begin
            hold_cnt_d = '0;
            fired_d    = 1'b0;
        end else if (HOLD_EN && level_q && !fired_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                hold_d  = 1'b1;
                fired_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            sync1_q    <= 1'b0;
            s_q        <= 1'b0;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            fired_q    <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_in;
            s_q        <= sync1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            fired_q    <= fired_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounced push-button channels.
// Pure fan-out of one debounce_channel per input bit.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEB_MAX  = DEB_MAX_FPGA,
    parameter int HOLD_MAX = 1000000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_hold
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEB_MAX  (DEB_MAX),
            .HOLD_MAX (HOLD_MAX)
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_hold    (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus queues expected strobes,
// a negedge monitor pops and compares them.
module tb_debounce_bank;
    import debounce_pkg::*;

    localparam int KP = 0;
    localparam int KR = 1;
    localparam int KH = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] btn;
    logic [3:0] lvl, prs, rls, hld;
    logic [0:0] zb, zl, zp, zr, zh;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   z_press_n = 0;
    int   z_rel_n = 0;
    int   z_hold_n = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_bank #(
        .N_CH     (4),
        .DEB_MAX  (DEB_MAX_SIM),
        .HOLD_MAX (20)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_in      (btn),
        .btn_level   (lvl),
        .btn_press   (prs),
        .btn_release (rls),
        .btn_hold    (hld)
    );

    debounce_bank #(
        .N_CH     (1),
        .DEB_MAX  (DEB_MAX_SIM),
        .HOLD_MAX (0)
    ) u_dut_z (
        .clk         (clk),
        .resetn      (resetn),
        .btn_in      (zb),
        .btn_level   (zl),
        .btn_press   (zp),
        .btn_release (zr),
        .btn_hold    (zh)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int off, input int ch, input int kind);
        ev_t e;
        e.cyc  = cyc + off;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Strobe monitor: every asserted strobe must match the queue head.
    always @(negedge clk) begin
        logic b;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing strobe: ch%0d kind%0d due cyc %0d, now %0d",
                     exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        for (int ch = 0; ch < 4; ch++) begin
            for (int k = 0; k < 3; k++) begin
                b = (k == KP) ? prs[ch] : (k == KR) ? rls[ch] : hld[ch];
                if (b) begin
                    checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc ||
                        exp_q[0].ch != ch || exp_q[0].kind != k) begin
                        errors++;
                        $display("FAIL unexpected strobe: ch%0d kind%0d at cyc %0d",
                                 ch, k, cyc);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        if (zp[0]) z_press_n++;
        if (zr[0]) z_rel_n++;
        if (zh[0]) z_hold_n++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        btn    = '0;
        zb     = '0;
        resetn = 1'b1;
        wait_n(3);
        resetn = 1'b0;
        wait_n(1);
        chk("rst_level", int'(lvl), 0);
        chk("rst_strobes", int'({prs, rls, hld}), 0);
        chk("rst_z", int'({zl, zp, zr, zh}), 0);
        wait_n(2);

        // 1: clean press with long hold
        btn[0] = 1'b1;
        expect_ev(7, 0, KP);
        expect_ev(27, 0, KH);
        wait_n(8);
        chk("t1_level", int'(lvl), 4'b0001);
        wait_n(32);
        btn[0] = 1'b0;
        expect_ev(7, 0, KR);
        wait_n(8);
        chk("t1_rel_level", int'(lvl), 0);
        wait_n(5);

        // 2: press bounce then clean press
        btn[1] = 1'b1; wait_n(3);
        btn[1] = 1'b0; wait_n(1);
        btn[1] = 1'b1; wait_n(3);
        btn[1] = 1'b0; wait_n(4);
        chk("t2_bounce_level", int'(lvl), 0);
        btn[1] = 1'b1;
        expect_ev(7, 1, KP);
        wait_n(8);
        chk("t2_level", int'(lvl), 4'b0010);
        wait_n(2);
        btn[1] = 1'b0;
        expect_ev(7, 1, KR);
        wait_n(12);

        // 3: release bounce, then real release (also a short hold)
        btn[2] = 1'b1;
        expect_ev(7, 2, KP);
        wait_n(10);
        btn[2] = 1'b0; wait_n(2);
        btn[2] = 1'b1; wait_n(3);
        chk("t3_bounce_level", int'(lvl), 4'b0100);
        btn[2] = 1'b0;
        expect_ev(7, 2, KR);
        wait_n(6);
        chk("t3_pre_rel_level", int'(lvl), 4'b0100);
        wait_n(2);
        chk("t3_rel_level", int'(lvl), 0);
        wait_n(5);

        // 4: ch0/ch3 together while ch1 is checking
        btn[1] = 1'b1;
        expect_ev(7, 1, KP);
        wait_n(3);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        expect_ev(7, 0, KP);
        expect_ev(7, 3, KP);
        wait_n(8);
        chk("t4_level", int'(lvl), 4'b1011);
        wait_n(1);
        btn = '0;
        expect_ev(7, 0, KR);
        expect_ev(7, 1, KR);
        expect_ev(7, 3, KR);
        wait_n(12);

        // 5: reset with ch0 DOWN and ch1 in PRESS_CHK
        btn[0] = 1'b1;
        expect_ev(7, 0, KP);
        wait_n(9);
        btn[1] = 1'b1;
        wait_n(4);
        resetn = 1'b1;
        wait_n(1);
        resetn = 1'b0;
        chk("t5_rst_level", int'(lvl), 0);
        chk("t5_rst_strobes", int'({prs, rls, hld}), 0);
        expect_ev(7, 0, KP);
        expect_ev(7, 1, KP);
        wait_n(6);
        chk("t5_pre_level", int'(lvl), 0);
        wait_n(2);
        chk("t5_level", int'(lvl), 4'b0011);
        wait_n(2);
        btn = '0;
        expect_ev(7, 0, KR);
        expect_ev(7, 1, KR);
        wait_n(12);

        // 6: hold disabled instance, 100-cycle press
        zb[0] = 1'b1;
        wait_n(100);
        chk("t6_z_level", int'(zl), 1);
        zb[0] = 1'b0;
        wait_n(10);
        chk("t6_z_rel_level", int'(zl), 0);
        chk("t6_z_hold", z_hold_n, 0);
        chk("t6_z_press", z_press_n, 1);
        chk("t6_z_release", z_rel_n, 1);

        wait_n(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button debouncer. It conditions N_CH raw button inputs with a per-channel synchroniser and a debounce state machine, and produces for each channel:
- a clean level,
- one-cycle press and release strobes,
- a one-shot long-press strobe.

It sits between the board buttons and the control FSMs. It replaces single-channel, press-only debouncing with symmetric press/release filtering.

## Interface
- N_CH, 4, number of independent button channels (>=1)
- DEB_MAX, 40000, consecutive stable cycles required to accept an edge (>=2; use 5 for simulation)
- HOLD_MAX, 1000000, cycles of accepted-pressed level before the long-press strobe; 0 disables it
- clk  in  1  system clock (1 MHz)
- resetn  in  1  synchronous, active-high reset
- btn_in  in  N_CH  raw, asynchronous, bouncy button inputs
- btn_level  out  N_CH  debounced level
- btn_press  out  N_CH  one-cycle strobe on accepted press
- btn_release  out  N_CH  one-cycle strobe on accepted release
- btn_hold  out  N_CH  one-cycle strobe, at most once per press, after HOLD_MAX pressed cycles

## Operation
Channels are fully independent and identical.

**Synchroniser**
- Two-flop synchroniser per channel; its output is called s.

**Per-channel FSM** (deb_cnt counts consecutive matching samples)
- IDLE
  - s=1 -> PRESS_CHK, deb_cnt=1.
- PRESS_CHK
  - s=0 -> IDLE, deb_cnt=0.
  - s=1 and deb_cnt==DEB_MAX-1 -> DOWN: btn_level<=1, btn_press<=1, deb_cnt=0.
  - s=1 otherwise -> deb_cnt+1.
- DOWN
  - s=0 -> REL_CHK, deb_cnt=1.
- REL_CHK
  - s=1 -> DOWN, deb_cnt=0.
  - s=0 and deb_cnt==DEB_MAX-1 -> IDLE: btn_level<=0, btn_release<=1.
  - s=0 otherwise -> deb_cnt+1.

**Hold counter** (hold_cnt)
- Counts every cycle while btn_level=1, including during REL_CHK.
- On reaching HOLD_MAX-1, btn_hold pulses once. hold_cnt then saturates and sets a fired flag.
- hold_cnt and the fired flag clear when btn_level returns to 0.
- If HOLD_MAX=0, btn_hold never asserts.

**Strobes**
- btn_press, btn_release and btn_hold are registered and default to 0 every cycle.

**Counter widths**
- deb_cnt width is $clog2(DEB_MAX).
- hold_cnt width is $clog2(HOLD_MAX+1), minimum 1.
- Neither counter ever wraps.

## Timing
- Reset: all FSMs go to IDLE; synchroniser flops, counters and fired flags go to 0. btn_level, btn_press, btn_release and btn_hold are all 0 on the cycle after the reset edge.
- Reset mid-operation aborts any check without emitting a strobe; no release strobe is generated for a channel that was down.
- Press latency: raw high first sampled at edge k and held -> btn_level/btn_press high after edge k+DEB_MAX+1. Release latency is symmetric.
- Any sample reverting during a check restarts filtering. A bounce shorter than DEB_MAX cycles never changes btn_level.
- btn_press and btn_release of one channel never assert in the same cycle.
- btn_hold can coincide with neither btn_press nor btn_release of the same channel.
- Simultaneous events on different channels are handled in the same cycle with no interaction.
- A button held through reset is treated as a new press: latency is DEB_MAX+1 from the first edge after reset deasserts.

## Structure
- Package debounce_pkg holds:
  - the channel state enum typedef (IDLE, PRESS_CHK, DOWN, REL_CHK);
  - default constants DEB_MAX_SIM=5 and DEB_MAX_FPGA=40000.
- Sub-module debounce_channel (synchroniser, FSM, both counters) is instantiated N_CH times via generate. The top level only fans bits in and out.

## Test plan
Bench parameters: N_CH=4, DEB_MAX=5, HOLD_MAX=20.

1. Clean press: btn_in[0] rises, first sampled at edge k, held 40 cycles. Required:
   - btn_press[0] pulses one cycle after edge k+6 and btn_level[0]=1;
   - btn_hold[0] pulses exactly once, 20 cycles after btn_level[0] rose;
   - other channels stay 0.
2. Press bounce: btn_in[1] high 3, low 1, high 3, low 4. Required: no strobes and btn_level[1]=0. Then held high 10. Required: one btn_press[1].
3. Release bounce: channel down, btn_in[2] low 2 cycles then high. Required: no btn_release[2] and btn_level[2] stays 1. Then low held. Required: btn_release[2] after DEB_MAX+1 cycles and btn_level[2]=0.
4. Simultaneity: btn_in[0] and btn_in[3] rise on the same edge while ch1 is mid-PRESS_CHK. Required:
   - press strobes on ch0 and ch3 in the same cycle;
   - ch1 timing unaffected.
5. Reset mid-operation: assert resetn for 1 cycle with ch0 in DOWN and ch1 in PRESS_CHK, buttons kept high. Required:
   - all outputs 0 next cycle and no release strobe;
   - new press strobes DEB_MAX+1 cycles after the first post-reset edge.
6. Short hold: release before 20 pressed cycles. Required: no btn_hold. Rerun with HOLD_MAX=0 and a 100-cycle press. Required: btn_hold never asserts.
